hms_timekeeper_ctrl: RTL and testbench



---
 rtl/hms_timekeeper_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hms_timekeeper_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hms_timekeeper_ctrl.sv
// hms_timekeeper_ctrl: time-of-day counter for the DE2 display path.
// Divides CLOCK_50 to a one-second tick, runs the HH:MM:SS cascade, and
// provides a RUN -> SET_HOUR -> SET_MIN set mode driven by two pushbuttons.
// While a field is being set, its blank flag flashes it.
module hms_timekeeper_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int BLINK_TICKS   = 12500000,
    parameter int PS_W          = 26
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    output logic [4:0] HOURS,
    output logic [5:0] MINUTES,
    output logic [5:0] SECONDS,
    output logic       sec_tick,
    output logic [1:0] mode,
    output logic       blank_hours,
    output logic       blank_minutes
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam logic [PS_W-1:0] PS_ZERO    = {PS_W{1'b0}};
    localparam logic [PS_W-1:0] PS_ONE     = PS_W'(1);
    localparam logic [PS_W-1:0] PS_LAST    = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [PS_W-1:0] BLINK_LAST = PS_W'(BLINK_TICKS - 1);

    // Button synchronizers and history flops (reset to "released").
    logic mode_meta_r, mode_sync_r, mode_hist_r;
    logic inc_meta_r, inc_sync_r, inc_hist_r;
    logic mode_evt_s, inc_evt_s;

    state_t          state_r, state_nx_s;
    logic [PS_W-1:0] ps_r, ps_nx_s;
    logic [PS_W-1:0] blink_cnt_r, blink_cnt_nx_s;
    logic            blink_r, blink_nx_s;
    logic [4:0]      hours_r, hours_nx_s;
    logic [5:0]      min_r, min_nx_s;
    logic [5:0]      sec_r, sec_nx_s;
    logic            sec_tick_r, sec_tick_nx_s;
    logic            blank_h_r, blank_m_r;
    logic            tick_s, blink_wrap_s;

    // Two-flop synchronizers plus a history flop per key.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            mode_meta_r <= 1'b1;
            mode_sync_r <= 1'b1;
            mode_hist_r <= 1'b1;
            inc_meta_r  <= 1'b1;
            inc_sync_r  <= 1'b1;
            inc_hist_r  <= 1'b1;
        end else begin
            mode_meta_r <= key_mode_n;
            mode_sync_r <= mode_meta_r;
            mode_hist_r <= mode_sync_r;
            inc_meta_r  <= key_inc_n;
            inc_sync_r  <= inc_meta_r;
            inc_hist_r  <= inc_sync_r;
        end
    end

    // A press is the high-to-low step between history and synced copies.
    assign mode_evt_s   = mode_hist_r & ~mode_sync_r;
    assign inc_evt_s    = inc_hist_r & ~inc_sync_r;
    assign tick_s       = (ps_r == PS_LAST);
    assign blink_wrap_s = (blink_cnt_r == BLINK_LAST);

    // Next-state logic: mode FSM, time cascade, prescaler and blink phase.
    always_comb begin
        state_nx_s     = state_r;
        hours_nx_s     = hours_r;
        min_nx_s       = min_r;
        sec_nx_s       = sec_r;
        sec_tick_nx_s  = 1'b0;
        ps_nx_s        = tick_s ? PS_ZERO : (ps_r + PS_ONE);
        blink_cnt_nx_s = blink_wrap_s ? PS_ZERO : (blink_cnt_r + PS_ONE);
        blink_nx_s     = blink_r ^ blink_wrap_s;
        case (state_r)
            ST_RUN: begin
                if (tick_s) begin
                    sec_tick_nx_s = 1'b1;
                    if (sec_r == 6'd59) begin
                        sec_nx_s = 6'd0;
                        if (min_r == 6'd59) begin
                            min_nx_s   = 6'd0;
                            hours_nx_s = (hours_r == 5'd23) ? 5'd0 : (hours_r + 5'd1);
                        end else begin
                            min_nx_s = min_r + 6'd1;
                        end
                    end else begin
                        sec_nx_s = sec_r + 6'd1;
                    end
                end else begin
                    sec_tick_nx_s = 1'b0;
                end
                // Blink phase is parked at "visible" so set-mode entry starts clean.
                blink_cnt_nx_s = PS_ZERO;
                blink_nx_s     = 1'b0;
                if (mode_evt_s) begin
                    state_nx_s = ST_SET_HOUR;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_SET_HOUR: begin
                if (mode_evt_s) begin
                    state_nx_s     = ST_SET_MIN;
                    blink_cnt_nx_s = PS_ZERO;
                    blink_nx_s     = 1'b0;
                end else if (inc_evt_s) begin
                    hours_nx_s     = (hours_r == 5'd23) ? 5'd0 : (hours_r + 5'd1);
                    blink_cnt_nx_s = PS_ZERO;
                    blink_nx_s     = 1'b0;
                end else begin
                    state_nx_s = ST_SET_HOUR;
                end
            end
            ST_SET_MIN: begin
                if (mode_evt_s) begin
                    // Restart the second from zero so the first tick is a full period away.
                    state_nx_s     = ST_RUN;
                    sec_nx_s       = 6'd0;
                    ps_nx_s        = PS_ZERO;
                    blink_cnt_nx_s = PS_ZERO;
                    blink_nx_s     = 1'b0;
                end else if (inc_evt_s) begin
                    min_nx_s       = (min_r == 6'd59) ? 6'd0 : (min_r + 6'd1);
                    blink_cnt_nx_s = PS_ZERO;
                    blink_nx_s     = 1'b0;
                end else begin
                    state_nx_s = ST_SET_MIN;
                end
            end
            default: begin
                state_nx_s     = ST_RUN;
                blink_cnt_nx_s = PS_ZERO;
                blink_nx_s     = 1'b0;
            end
        endcase
    end

    // State, counters and registered display outputs.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_r     <= ST_RUN;
            ps_r        <= PS_ZERO;
            blink_cnt_r <= PS_ZERO;
            blink_r     <= 1'b0;
            hours_r     <= 5'd0;
            min_r       <= 6'd0;
            sec_r       <= 6'd0;
            sec_tick_r  <= 1'b0;
            blank_h_r   <= 1'b0;
            blank_m_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            ps_r        <= ps_nx_s;
            blink_cnt_r <= blink_cnt_nx_s;
            blink_r     <= blink_nx_s;
            hours_r     <= hours_nx_s;
            min_r       <= min_nx_s;
            sec_r       <= sec_nx_s;
            sec_tick_r  <= sec_tick_nx_s;
            blank_h_r   <= (state_nx_s == ST_SET_HOUR) & blink_nx_s;
            blank_m_r   <= (state_nx_s == ST_SET_MIN) & blink_nx_s;
        end
    end

    assign HOURS         = hours_r;
    assign MINUTES       = min_r;
    assign SECONDS       = sec_r;
    assign sec_tick      = sec_tick_r;
    assign mode          = state_r;
    assign blank_hours   = blank_h_r;
    assign blank_minutes = blank_m_r;

endmodule

// File: tb/tb_hms_timekeeper_ctrl.sv
// Scoreboard bench for hms_timekeeper_ctrl with a shortened time base.
module tb_hms_timekeeper_ctrl;

    localparam int TPS = 4;
    localparam int BT  = 2;
    localparam int PSW = 3;

    logic       CLOCK_50   = 1'b0;
    logic       Resetn     = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       key_inc_n  = 1'b1;
    logic [4:0] HOURS;
    logic [5:0] MINUTES;
    logic [5:0] SECONDS;
    logic       sec_tick;
    logic [1:0] mode;
    logic       blank_hours;
    logic       blank_minutes;

    hms_timekeeper_ctrl #(
        .TICKS_PER_SEC(TPS),
        .BLINK_TICKS  (BT),
        .PS_W         (PSW)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .Resetn       (Resetn),
        .key_mode_n   (key_mode_n),
        .key_inc_n    (key_inc_n),
        .HOURS        (HOURS),
        .MINUTES      (MINUTES),
        .SECONDS      (SECONDS),
        .sec_tick     (sec_tick),
        .mode         (mode),
        .blank_hours  (blank_hours),
        .blank_minutes(blank_minutes)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string tag;
        int    h;
        int    m;
        int    s;
        int    md;
        int    st;
        int    bh;
        int    bm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   range_bad = 0;
    int   tick_wide = 0;
    logic tick_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int h, input int m, input int s,
                           input int md, input int st, input int bh, input int bm);
        exp_t e;
        e.tag = tag; e.h = h; e.m = m; e.s = s;
        e.md = md; e.st = st; e.bh = bh; e.bm = bm;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".hours"},   HOURS,         e.h);
            chk({e.tag, ".minutes"}, MINUTES,       e.m);
            chk({e.tag, ".seconds"}, SECONDS,       e.s);
            chk({e.tag, ".mode"},    mode,          e.md);
            chk({e.tag, ".sec_tick"}, sec_tick,     e.st);
            chk({e.tag, ".blank_h"}, blank_hours,   e.bh);
            chk({e.tag, ".blank_m"}, blank_minutes, e.bm);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Key goes low; the update lands on the third edge, then the key is released.
    task automatic press(input bit pm, input bit pi);
        if (pm) key_mode_n = 1'b0;
        if (pi) key_inc_n = 1'b0;
        cyc(3);
        sb_check();
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
        cyc(3);
    endtask

    // Watch for out-of-range time values and sec_tick pulses wider than one cycle.
    always @(negedge CLOCK_50) begin
        if (Resetn) begin
            if (HOURS > 5'd23 || MINUTES > 6'd59 || SECONDS > 6'd59) range_bad <= range_bad + 1;
            if (sec_tick && tick_prev) tick_wide <= tick_wide + 1;
        end
        tick_prev <= sec_tick;
    end

    initial begin
        int n;
        // Reset takes effect without a clock edge.
        #1 Resetn = 1'b0;
        #1;
        sb_push("reset_async", 0, 0, 0, 0, 0, 0, 0);
        sb_check();
        cyc(2);
        sb_push("reset_hold", 0, 0, 0, 0, 0, 0, 0);
        sb_check();
        Resetn = 1'b1;

        // Free run: tick every 4 cycles, 59 -> 0 wrap with minute carry at cycle 240.
        for (int i = 1; i <= 253; i++) begin
            sb_push("run", 0, i / 240, (i / 4) % 60, 0, (i % 4 == 0) ? 1 : 0, 0, 0);
            cyc(1);
            sb_check();
        end

        // Prescaler is at 1: the mode press lands on the same edge as a tick.
        sb_push("mode_tick_coincide", 0, 1, 4, 1, 1, 0, 0);
        press(1'b1, 1'b0);

        for (int i = 1; i <= 25; i++) begin
            sb_push("set_hour_inc", i % 24, 1, 4, 1, 0, 0, 0);
            press(1'b0, 1'b1);
        end

        // Blink phase after an inc press: visible 2 cycles, blank 2 cycles.
        for (int k = 4; k <= 11; k++) begin
            sb_push("blink_hour", 1, 1, 4, 1, 0, (k / 2) % 2, 0);
            cyc(1);
            sb_check();
        end
        sb_push("inc_unblank", 2, 1, 4, 1, 0, 0, 0);
        press(1'b0, 1'b1);

        for (int i = 3; i <= 23; i++) begin
            sb_push("set_hour_inc", i, 1, 4, 1, 0, 0, 0);
            press(1'b0, 1'b1);
        end

        sb_push("mode_beats_inc", 23, 1, 4, 2, 0, 0, 0);
        press(1'b1, 1'b1);

        for (int i = 1; i <= 61; i++) begin
            sb_push("set_min_inc", 23, (1 + i) % 60, 4, 2, 0, 0, 0);
            press(1'b0, 1'b1);
        end
        for (int i = 3; i <= 59; i++) begin
            sb_push("set_min_inc", 23, i, 4, 2, 0, 0, 0);
            press(1'b0, 1'b1);
        end
        for (int k = 4; k <= 7; k++) begin
            sb_push("blink_min", 23, 59, 4, 2, 0, 0, (k / 2) % 2);
            cyc(1);
            sb_check();
        end

        sb_push("exit_clears_sec", 23, 59, 0, 0, 0, 0, 0);
        press(1'b1, 1'b0);

        // First tick lands 4 edges after exit; inc in RUN changes nothing.
        sb_push("inc_ignored_run", 23, 59, 1, 0, 0, 0, 0);
        press(1'b0, 1'b1);

        // Run through 23:59:59 -> 00:00:00.
        for (int j = 10; j <= 244; j++) begin
            n = j / 4;
            if (n < 60) sb_push("midnight", 23, 59, n, 0, (j % 4 == 0) ? 1 : 0, 0, 0);
            else        sb_push("midnight", 0, 0, n - 60, 0, (j % 4 == 0) ? 1 : 0, 0, 0);
            cyc(1);
            sb_check();
        end

        sb_push("enter_set_hour", 0, 0, 1, 1, 0, 0, 0);
        press(1'b1, 1'b0);
        sb_push("enter_set_min", 0, 0, 1, 2, 0, 0, 0);
        press(1'b1, 1'b0);

        // Reset mid-SET_MIN with inc held low.
        key_inc_n = 1'b0;
        cyc(1);
        Resetn = 1'b0;
        #1;
        sb_push("reset_mid_set", 0, 0, 0, 0, 0, 0, 0);
        sb_check();
        cyc(2);
        Resetn = 1'b1;
        sb_push("post_reset_run", 0, 0, 1, 0, 0, 0, 0);
        cyc(6);
        sb_check();
        key_inc_n = 1'b1;
        cyc(3);

        chk("range_monitor", range_bad, 0);
        chk("tick_width", tick_wide, 0);
        chk("sb_leftover", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
